// File: rtl/pn_pulse_gen_mc.sv
// ---------------------------------------------------------------------------
// pn_pulse_gen_mc
//   Multi-channel PN-modulated pulse generator. One shared period counter
//   (0..PERIOD-1) drives NCH channel lanes. Each lane latches a pulse width
//   derived from its PN byte at its own period start. It then holds its pulse
//   high for that many clocks and low for the rest of the period.
//
//   Optional feature macro: PN_PULSE_STAGGER_EN
//     defined   : channel i starts its period when cnt == (i*STAGGER) mod PERIOD
//     undefined : all channels start together at cnt == 0, STAGGER ignored
//
// Ports
//   clk           clock
//   rst           synchronous, active-low reset
//   en            run enable; low clears counter and pulses, width_q holds
//   pn            PN bytes, channel i = pn[i*PN_W +: PN_W]
//   pulse         registered pulse outputs, one per channel
//   period_start  1-cycle strobe in the first cycle of channel 0's period
//   width_q       latched width of each channel's current period
// ---------------------------------------------------------------------------

// One channel: width map, width latch, pulse compare.
module pn_pulse_lane #(
  parameter int PN_W   = 8,
  parameter int CNT_W  = 8,
  parameter int PERIOD = 30,
  parameter int SHIFT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,    // this edge begins the lane's period
  input  logic [CNT_W-1:0] phase,    // clocks since lane's period start
  input  logic [PN_W-1:0]  pn,
  output logic             pulse,
  output logic [CNT_W-1:0] width_q
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] s, a, w, width_d;
  logic             pulse_q, pulse_d;
  logic             started_q, started_d;

  // Fold oversize values back into 1..PERIOD-1 so duty is never 0% or 100%.
  always_comb begin
    s = CNT_W'(pn >> SHIFT);
    a = (s > LAST) ? s - LAST : s;
    w = (a == '0) ? CNT_W'(1) : a;
  end

  // started_q keeps a staggered lane low until its first period start
  // after reset or enable.
  always_comb begin
    pulse_d   = 1'b0;
    started_d = started_q;
    width_d   = width_q;
    if (!en) begin
      started_d = 1'b0;
    end else if (start) begin
      started_d = 1'b1;
      width_d   = w;
      pulse_d   = 1'b1;
    end else begin
      pulse_d   = started_q && (phase < width_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_q   <= 1'b0;
      started_q <= 1'b0;
      width_q   <= '0;
    end else begin
      pulse_q   <= pulse_d;
      started_q <= started_d;
      width_q   <= width_d;
    end
  end

  assign pulse = pulse_q;
endmodule

module pn_pulse_gen_mc #(
  parameter int NCH     = 4,
  parameter int PN_W    = 8,
  parameter int CNT_W   = 8,
  parameter int PERIOD  = 30,
  parameter int SHIFT   = 3,
  parameter int STAGGER = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH*PN_W-1:0]   pn,
  output logic [NCH-1:0]        pulse,
  output logic                  period_start,
  output logic [NCH*CNT_W-1:0]  width_q
);
`ifdef PN_PULSE_STAGGER_EN
  localparam bit STAGGER_ON = 1'b1;
`else
  localparam bit STAGGER_ON = 1'b0;
`endif
  localparam int               STG  = STAGGER_ON ? STAGGER : 0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;

  always_comb begin
    cnt_d          = '0;
    period_start_d = 1'b0;
    if (en) begin
      cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      period_start_d = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int OFS = (i * STG) % PERIOD;
    // Lane phase = (cnt - OFS) mod PERIOD, done as cnt + (PERIOD-OFS) with
    // one conditional subtract; one extra bit holds the sum. With OFS=0 this
    // collapses to cnt.
    localparam logic [CNT_W:0] ADD = (CNT_W+1)'(PERIOD - OFS);
    localparam logic [CNT_W:0] PER = (CNT_W+1)'(PERIOD);

    logic [CNT_W:0]   ph_ext;
    logic [CNT_W-1:0] phase;

    assign ph_ext = {1'b0, cnt_q} + ADD;
    assign phase  = (ph_ext >= PER) ? CNT_W'(ph_ext - PER) : CNT_W'(ph_ext);

    pn_pulse_lane #(
      .PN_W   (PN_W),
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .start   (phase == '0),
      .phase   (phase),
      .pn      (pn[i*PN_W +: PN_W]),
      .pulse   (pulse[i]),
      .width_q (width_q[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_pn_pulse_gen_mc.sv
// Scoreboard bench for pn_pulse_gen_mc. The driver pushes the expected
// post-edge outputs for every cycle; the monitor pops and compares them.
module tb_pn_pulse_gen_mc;
  localparam int NCH = 4, PN_W = 8, CNT_W = 8, PERIOD = 30, SHIFT = 3, STAGGER = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en  = 1'b0;
  logic [NCH*PN_W-1:0]  pn  = '0;
  logic [NCH-1:0]       pulse;
  logic                 period_start;
  logic [NCH*CNT_W-1:0] width_q;

  pn_pulse_gen_mc #(.NCH(NCH), .PN_W(PN_W), .CNT_W(CNT_W), .PERIOD(PERIOD),
                    .SHIFT(SHIFT), .STAGGER(STAGGER)) dut (
    .clk(clk), .rst(rst), .en(en), .pn(pn),
    .pulse(pulse), .period_start(period_start), .width_q(width_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]       pulse;
    logic                 ps;
    logic [NCH*CNT_W-1:0] wq;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // Reference state: number of consecutive active edges, latched widths,
  // and whether each channel has seen its first period start.
  int active_n = 0;
  int mw[NCH];
  bit armed[NCH];

  function automatic int wmap(int pnv);
    int s, a;
    s = pnv >> SHIFT;
    a = (s > PERIOD - 1) ? s - (PERIOD - 1) : s;
    return (a == 0) ? 1 : a;
  endfunction

  function automatic int ofs(int i);
`ifdef PN_PULSE_STAGGER_EN
    return (i * STAGGER) % PERIOD;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input bit r, input bit e, input logic [NCH*PN_W-1:0] p);
    exp_t x;
    int   pp, ph;
    @(negedge clk);
    rst = r; en = e; pn = p;
    x.pulse = '0; x.ps = 1'b0; x.wq = '0;
    if (!r) begin
      active_n = 0;
      for (int i = 0; i < NCH; i++) begin mw[i] = 0; armed[i] = 0; end
    end else if (!e) begin
      active_n = 0;
      for (int i = 0; i < NCH; i++) armed[i] = 0;
    end else begin
      pp = active_n % PERIOD;
      x.ps = (pp == 0);
      for (int i = 0; i < NCH; i++) begin
        ph = (pp - ofs(i) + PERIOD) % PERIOD;
        if (ph == 0) begin
          armed[i] = 1;
          mw[i]    = wmap(int'(p[i*PN_W +: PN_W]));
        end
        x.pulse[i] = armed[i] && (ph < mw[i]);
      end
      active_n++;
    end
    for (int i = 0; i < NCH; i++) x.wq[i*CNT_W +: CNT_W] = CNT_W'(mw[i]);
    q.push_back(x);
  endtask

  // Monitor: outputs are registered, so compare every cycle just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        compared++;
        if (pulse !== x.pulse || period_start !== x.ps || width_q !== x.wq) begin
          mismatched++;
          $display("FAIL outputs cyc=%0d got pulse=%b ps=%b wq=%h expected pulse=%b ps=%b wq=%h",
                   cyc, pulse, period_start, width_q, x.pulse, x.ps, x.wq);
        end
      end
    end
  end

  initial begin
    logic [NCH*PN_W-1:0] p;
    bit r, e;
    // Reset, including reset dominating en.
    repeat (3) drive(0, 0, '0);
    repeat (2) drive(0, 1, 32'h50505050);
    // Nominal and width-map edges.
    repeat (65) drive(1, 1, {8'hF8, 8'hE8, 8'h00, 8'h50});
    repeat (62) drive(1, 1, {8'hFF, 8'hF0, 8'h28, 8'h50});
    // Mid-period pn change must not affect the current pulse.
    repeat (33) drive(1, 1, 32'h50505050);
    repeat (60) drive(1, 1, 32'h28282828);
    // Enable drop mid-pulse, then fresh restart.
    repeat (4)  drive(1, 1, 32'h50505050);
    repeat (16) drive(1, 0, 32'h50505050);
    repeat (40) drive(1, 1, 32'h48607080);
    // Reset mid-pulse, then restart.
    repeat (5)  drive(1, 1, 32'h50505050);
    drive(0, 1, 32'h50505050);
    repeat (40) drive(1, 1, 32'h50505050);
    // Randomized run.
    p = 32'h50505050;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) p = $urandom;
      e = ($urandom_range(39) != 0);
      r = ($urandom_range(199) != 0);
      drive(r, e, p);
    end
    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
